wb_sequencer: RTL
=================

Name: wb_sequencer

Overview:
- Sequences register-file write-back for one instruction at a time.
- Latches the write-back operands: ALU result, PC+4, and I/O/memory read data.
- Drives the 2-bit regfile-input select, the write enable and the write address to the write-back mux and register file.
- Runs the I/O read handshake for IO-sourced writes, with a timeout and sticky error flags.
- Sits between the decoder/execute stage and the regfile-input mux.

Parameters:
DBITS, 32, data width of operands and write-back data
REGBITS, 4, register address width
TIMEOUT, 16, max cycles waiting for mem_rdy; 0 = wait forever

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
instr_valid  in  1  instruction presented for write-back
in_ready  out  1  sequencer can accept an instruction (high only in IDLE)
wr_reg  in  1  instruction writes a register
sel_in  in  2  requested source: 2'b00 ALUOUT, 2'b01 PCPLUS4, 2'b10 IO, 2'b11 illegal
dest_in  in  REGBITS  destination register
alu_in  in  DBITS  ALU result
pc_in  in  DBITS  PC+4
mem_req  out  1  I/O read request
mem_rdy  in  1  I/O read data valid
mem_data  in  DBITS  I/O read data
alu_q  out  DBITS  latched ALU operand to mux
pc_q  out  DBITS  latched PC+4 operand to mux
mem_q  out  DBITS  latched I/O operand to mux
regfile_in_sel  out  2  select to write-back mux
rf_we  out  1  register-file write enable
rf_waddr  out  REGBITS  register-file write address
retire  out  1  one-cycle pulse: instruction finished
illegal_err  out  1  sticky: illegal select seen
timeout_err  out  1  sticky: I/O read timed out

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; in_ready 1 from the first cycle after reset; all other outputs 0, including alu_q/pc_q/mem_q, regfile_in_sel 2'b00, both error flags.
- Reset mid-operation: abandons the instruction. mem_req and rf_we drop at the reset edge. No write, no retire.

States: IDLE, WAIT_MEM, WRITE, DONE.

IDLE, accept on instr_valid && in_ready at edge N:
- Latch alu_q, pc_q, rf_waddr = dest_in, regfile_in_sel = sel_in.
- wr_reg = 0: go to DONE; no write.
- wr_reg = 1, sel ALUOUT/PCPLUS4: go to WRITE.
- wr_reg = 1, sel IO: go to WAIT_MEM; mem_req = 1 from cycle N+1; wait counter cleared.
- wr_reg = 1, sel 2'b11: set illegal_err, go to DONE; no write.

WAIT_MEM:
- Hold mem_req high. Counter increments each cycle.
- On mem_rdy: latch mem_q = mem_data, drop mem_req, go to WRITE.
- TIMEOUT != 0 and counter reaches TIMEOUT-1 without mem_rdy: drop mem_req, set timeout_err, go to DONE; no write.
- mem_rdy on the timeout cycle counts as success.
- mem_rdy outside WAIT_MEM is ignored.

WRITE:
- rf_we = 1 for exactly one cycle, with regfile_in_sel and rf_waddr stable and the matching *_q operand valid.
- Next state DONE.

DONE:
- retire = 1 for one cycle, then IDLE.
- in_ready rises in the cycle after the retire pulse.

Timing:
- ALU/PC write-back: accept at N, rf_we in N+1, retire in N+2, in_ready in N+3.
- IO write-back: rf_we one cycle after the mem_rdy edge.
- instr_valid while in_ready = 0 is ignored; the upstream stage holds it.

Outputs between instructions:
- regfile_in_sel, rf_waddr and *_q hold their last values.
- rf_we is 0 outside WRITE.

Error flags are cleared only by reset.

Test Plan:
- ALU write: reset; instr_valid, wr_reg=1, sel=00, dest=5, alu_in=0x1234 at N -> N+1: rf_we=1, rf_waddr=5, sel=00, alu_q=0x1234; N+2: retire=1; N+3: in_ready=1.
- PC write: sel=01, dest=15, pc_in=0x40 -> single rf_we with pc_q=0x40, sel=01; no mem_req.
- IO read: sel=10, dest=3; mem_rdy with mem_data=0xDEADBEEF 4 cycles after mem_req rises -> mem_req high exactly 4 cycles; next cycle rf_we=1, mem_q=0xDEADBEEF, sel=10; then retire.
- IO timeout: TIMEOUT=16, mem_rdy never asserted -> mem_req high 16 cycles then low; timeout_err=1; no rf_we; retire pulses; second IO instruction then completes normally with timeout_err still 1.
- No-write and illegal: wr_reg=0 -> retire at N+1, no rf_we. wr_reg=1, sel=11 -> illegal_err=1, no rf_we, retire.
- Reset mid-wait: reset asserted in the 2nd WAIT_MEM cycle -> next edge mem_req=0, in_ready=1, no retire, flags 0; late mem_rdy causes no write.

Source files
------------

// File: rtl/wb_sequencer.sv
// rtl/wb_sequencer.sv - register-file write-back sequencer with I/O read handshake
module wb_sequencer #(
    parameter int DBITS   = 32,
    parameter int REGBITS = 4,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    output logic               in_ready,
    input  logic               wr_reg,
    input  logic [1:0]         sel_in,
    input  logic [REGBITS-1:0] dest_in,
    input  logic [DBITS-1:0]   alu_in,
    input  logic [DBITS-1:0]   pc_in,
    output logic               mem_req,
    input  logic               mem_rdy,
    input  logic [DBITS-1:0]   mem_data,
    output logic [DBITS-1:0]   alu_q,
    output logic [DBITS-1:0]   pc_q,
    output logic [DBITS-1:0]   mem_q,
    output logic [1:0]         regfile_in_sel,
    output logic               rf_we,
    output logic [REGBITS-1:0] rf_waddr,
    output logic               retire,
    output logic               illegal_err,
    output logic               timeout_err
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_PC  = 2'b01;
    localparam logic [1:0] SEL_IO  = 2'b10;
    localparam logic [1:0] SEL_BAD = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_WAIT_MEM, S_WRITE, S_DONE} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [CW-1:0]        r_cnt;
    logic                 r_in_ready;
    logic                 r_mem_req;
    logic                 r_rf_we;
    logic                 r_retire;
    logic                 r_illegal_err;
    logic                 r_timeout_err;
    logic [DBITS-1:0]     r_alu_q;
    logic [DBITS-1:0]     r_pc_q;
    logic [DBITS-1:0]     r_mem_q;
    logic [1:0]           r_sel;
    logic [REGBITS-1:0]   r_waddr;

    logic w_accept;
    logic w_mem_hit;
    logic w_timeout;
    logic w_illegal;
    logic w_in_ready_next;
    logic w_mem_req_next;
    logic w_rf_we_next;
    logic w_retire_next;

    assign w_accept  = instr_valid && r_in_ready;
    assign w_mem_hit = (r_state == S_WAIT_MEM) && mem_rdy;
    assign w_timeout = (TIMEOUT != 0) && (r_state == S_WAIT_MEM) && !mem_rdy && (r_cnt == CNT_LAST);
    assign w_illegal = w_accept && wr_reg && (sel_in == SEL_BAD);

    // State, counter, operand latches and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_in_ready    <= 1'b1;
            r_mem_req     <= 1'b0;
            r_rf_we       <= 1'b0;
            r_retire      <= 1'b0;
            r_illegal_err <= 1'b0;
            r_timeout_err <= 1'b0;
            r_alu_q       <= '0;
            r_pc_q        <= '0;
            r_mem_q       <= '0;
            r_sel         <= SEL_ALU;
            r_waddr       <= '0;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= w_in_ready_next;
            r_mem_req  <= w_mem_req_next;
            r_rf_we    <= w_rf_we_next;
            r_retire   <= w_retire_next;
            if (w_accept) begin
                r_alu_q <= alu_in;
                r_pc_q  <= pc_in;
                r_sel   <= sel_in;
                r_waddr <= dest_in;
                r_cnt   <= '0;
            end else if (r_state == S_WAIT_MEM) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_mem_hit) begin
                r_mem_q <= mem_data;
            end
            if (w_illegal) begin
                r_illegal_err <= 1'b1;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    // Next-state decision
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!wr_reg) begin
                        w_state_next = S_DONE;
                    end else begin
                        case (sel_in)
                            SEL_ALU, SEL_PC: w_state_next = S_WRITE;
                            SEL_IO:          w_state_next = S_WAIT_MEM;
                            default:         w_state_next = S_DONE;
                        endcase
                    end
                end
            end
            S_WAIT_MEM: begin
                if (mem_rdy) begin
                    w_state_next = S_WRITE;
                end else if (w_timeout) begin
                    w_state_next = S_DONE;
                end
            end
            S_WRITE: w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs follow the state being entered so they are registered without extra latency
    always_comb begin
        w_in_ready_next = (w_state_next == S_IDLE);
        w_mem_req_next  = (w_state_next == S_WAIT_MEM);
        w_rf_we_next    = (w_state_next == S_WRITE);
        w_retire_next   = (w_state_next == S_DONE);
    end

    assign in_ready       = r_in_ready;
    assign mem_req        = r_mem_req;
    assign rf_we          = r_rf_we;
    assign retire         = r_retire;
    assign illegal_err    = r_illegal_err;
    assign timeout_err    = r_timeout_err;
    assign alu_q          = r_alu_q;
    assign pc_q           = r_pc_q;
    assign mem_q          = r_mem_q;
    assign regfile_in_sel = r_sel;
    assign rf_waddr       = r_waddr;
endmodule
